uart_rx_frame_ctrl: RTL and testbench

//  Sequencer and back-end for the Hamming(7,4) UART receiver.
//  - Generates the receiver's oversample enable (8 ticks per bit).
//  - Takes each valid 7-bit codeword, corrects single-bit errors and pairs two nibbles into a byte.
//  - Buffers bytes in a small FIFO with a ready/valid output to the host logic.
//  - Tracks corrected errors, FIFO overflow and inter-nibble timeouts.

---
 rtl/uart_rx_frame_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Sequencer and back-end for the Hamming(7,4) UART receiver.
//   - Divides clk down to the receiver's 8x-baud oversample tick (rx_ena).
//   - On each new receiver frame, corrects a single-bit error in the 7-bit
//     codeword and pairs two decoded nibbles (low first) into a byte.
//   - Buffers bytes in a show-ahead FIFO with a ready/valid host interface.
//   - Reports corrected codewords, FIFO overflow and inter-nibble timeouts.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   enable        block enable; low stalls the divider and aborts pairing
//   rx_data[6:0]  codeword, bit i = Hamming position i+1
//   rx_valid      receiver frame-valid (only its rising edge is used)
//   rx_state[1:0] receiver state, 2'b00 = IDLE
//   rx_ena        one-cycle oversample tick to the receiver
//   byte_data     FIFO head byte (show-ahead)
//   byte_valid    FIFO not empty
//   byte_ready    consumer accepts byte_data when byte_valid & byte_ready
//   err_pulse     one-cycle pulse after a codeword that needed correction
//   err_count     corrected-codeword count, saturating at 255
//   overflow      sticky: a byte was dropped because the FIFO was full
//   timeout       one-cycle pulse when a dangling low nibble is discarded
//   clear_err     synchronous clear of err_count and overflow
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
  parameter int CLK_DIV       = 13,
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_TICKS = 96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] rx_data,
  input  logic       rx_valid,
  input  logic [1:0] rx_state,
  output logic       rx_ena,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic       overflow,
  output logic       timeout,
  input  logic       clear_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } pair_state_e;

  // Registered state
  logic [DIV_W-1:0] div_q, div_d;
  logic             valid_prev_q, valid_prev_d;
  pair_state_e      state_q, state_d;
  logic [3:0]       lo_nib_q, lo_nib_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Combinational helpers
  logic [2:0] syn;
  logic [6:0] corr;
  logic [3:0] nibble;
  logic       frame_edge;
  logic       push, pop, full, accept, drop;
  logic [7:0] push_data;

  // Hamming(7,4) syndrome: the value names the 1-based position in error.
  always_comb begin
    syn = {rx_data[3] ^ rx_data[4] ^ rx_data[5] ^ rx_data[6],
           rx_data[1] ^ rx_data[2] ^ rx_data[5] ^ rx_data[6],
           rx_data[0] ^ rx_data[2] ^ rx_data[4] ^ rx_data[6]};
    for (int i = 0; i < 7; i++) begin
      corr[i] = rx_data[i] ^ (syn == 3'(i + 1));
    end
    nibble = {corr[6], corr[5], corr[4], corr[2]};
  end

  // A frame is the rising edge of rx_valid; a stalled block ignores frames.
  assign frame_edge = enable & rx_valid & ~valid_prev_q;
  assign rx_ena     = enable & (div_q == DIV_W'(CLK_DIV - 1));

  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop    = (count_q != '0) & byte_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    div_d        = div_q;
    valid_prev_d = rx_valid;
    state_d      = state_q;
    lo_nib_d     = lo_nib_q;
    tmo_d        = tmo_q;
    timeout_d    = 1'b0;
    push         = 1'b0;
    push_data    = {nibble, lo_nib_q};
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    // Oversample divider
    if (!enable)             div_d = '0;
    else if (rx_ena)         div_d = '0;
    else                     div_d = div_q + DIV_W'(1);

    // Nibble pairing
    if (!enable) begin
      state_d = WAIT_LO;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_LO: begin
          if (frame_edge) begin
            lo_nib_d = nibble;
            tmo_d    = '0;
            state_d  = WAIT_HI;
          end
        end
        WAIT_HI: begin
          // A frame arriving in the expiry cycle takes priority over timeout.
          if (frame_edge) begin
            push    = 1'b1;
            state_d = WAIT_LO;
          end else if (rx_state != 2'b00) begin
            tmo_d = '0;
          end else if (rx_ena) begin
            if (tmo_q == TMO_W'(TIMEOUT_TICKS - 1)) begin
              timeout_d = 1'b1;
              tmo_d     = '0;
              state_d   = WAIT_LO;
            end else begin
              tmo_d = tmo_q + TMO_W'(1);
            end
          end
        end
        default: state_d = WAIT_LO;
      endcase
    end

    // Error reporting; clear wins over a coincident increment.
    err_pulse_d = frame_edge & (syn != 3'b000);
    if (clear_err)
      err_count_d = 8'd0;
    else if (err_pulse_d && err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
    else
      err_count_d = err_count_q;
    overflow_d = clear_err ? 1'b0 : (overflow_q | drop);

    // FIFO; power-of-2 depth lets the pointers wrap naturally.
    if (accept) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      valid_prev_q <= 1'b0;
      state_q      <= WAIT_LO;
      lo_nib_q     <= '0;
      tmo_q        <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      // NOTE: the storage is reset as well; it is only a few bytes and it
      // keeps byte_data at a defined 0 out of reset.
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      div_q        <= div_d;
      valid_prev_q <= valid_prev_d;
      state_q      <= state_d;
      lo_nib_q     <= lo_nib_d;
      tmo_q        <= tmo_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign byte_data  = mem_q[rd_ptr_q];
  assign byte_valid = (count_q != '0);
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
//   Self-checking bench for uart_rx_frame_ctrl. Inputs change 1 ns after the
//   rising edge; outputs are sampled on the falling edge. Expected bytes go
//   into a scoreboard queue when the high codeword is driven and are compared
//   whenever the DUT hands a byte over (byte_valid & byte_ready).
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  localparam int CLK_DIV       = 13;
  localparam int FIFO_DEPTH    = 4;
  localparam int TIMEOUT_TICKS = 96;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [1:0] rx_state = 2'b00;
  logic       rx_ena;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       overflow;
  logic       timeout;
  logic       clear_err = 1'b0;

  uart_rx_frame_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_state  (rx_state),
    .rx_ena    (rx_ena),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .overflow  (overflow),
    .timeout   (timeout),
    .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int err_pulses   = 0;
  int exp_pulses   = 0;
  int exp_err_cnt  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: data bits at positions 3,5,6,7, parity at 1,2,4.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c    = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = c[2] ^ c[4] ^ c[6];
    c[1] = c[2] ^ c[5] ^ c[6];
    c[3] = c[4] ^ c[5] ^ c[6];
    return c;
  endfunction

  // Scoreboard / event monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_pulse) err_pulses++;
      if (byte_valid && byte_ready) begin
        check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("byte_data", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One receiver frame: valid held high 3 cycles (level must be ignored).
  task automatic send_cw(input logic [6:0] cw, input bit pop_now = 1'b0);
    rx_state = 2'b01;
    rx_data  = cw;
    rx_valid = 1'b1;
    if (pop_now) byte_ready = 1'b1;
    step();
    if (pop_now) byte_ready = 1'b0;
    step(2);
    rx_valid = 1'b0;
    rx_state = 2'b00;
    step();
  endtask

  task automatic send_byte(input logic [6:0] lo, input logic [6:0] hi, input logic [7:0] exp_b,
                           input bit expect_push = 1'b1);
    send_cw(lo);
    if (expect_push) exp_q.push_back(exp_b);
    send_cw(hi);
  endtask

  typedef struct {
    logic [6:0] lo_cw;
    logic [6:0] hi_cw;
    logic [7:0] exp_byte;
    int         exp_errs;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int pulses;
    int ticks;
    bit seen;

    // Vector table: hand-derived rows, then random encodings with 0/1 flips.
    vecs[0] = '{7'h2D, 7'h52, 8'hA5, 0};
    vecs[1] = '{7'h29, 7'h52, 8'hA5, 1};  // c2 flipped in the low codeword
    vecs[2] = '{7'h00, 7'h7F, 8'hF0, 0};
    vecs[3] = '{7'h2D, 7'h53, 8'hA5, 1};  // c0 flipped in the high codeword
    vecs[4] = '{7'h3F, 7'h08, 8'h0F, 2};  // c6 and c3 flipped
    for (int r = 5; r < 13; r++) begin
      logic [3:0] lo_n, hi_n;
      int         f_lo, f_hi;
      lo_n = 4'($urandom_range(15));
      hi_n = 4'($urandom_range(15));
      f_lo = $urandom_range(7);
      f_hi = $urandom_range(7);
      vecs[r].lo_cw    = enc(lo_n) ^ ((f_lo < 7) ? 7'(1 << f_lo) : 7'd0);
      vecs[r].hi_cw    = enc(hi_n) ^ ((f_hi < 7) ? 7'(1 << f_hi) : 7'd0);
      vecs[r].exp_byte = {hi_n, lo_n};
      vecs[r].exp_errs = int'(f_lo < 7) + int'(f_hi < 7);
    end

    // Reset state
    step(3);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_err_count", err_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_rx_ena", rx_ena, 0);

    // Divider: silent while disabled, then ticks on every 13th cycle
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_ena) pulses++;
    end
    check("div_disabled_pulses", pulses, 0);
    step();
    enable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      check($sformatf("div_tick_cycle%0d", i), rx_ena, 32'((i % CLK_DIV) == 0));
    end
    step();

    // Clean byte with exact latency: byte_valid rises one cycle after the edge
    send_cw(7'h2D);
    exp_q.push_back(8'hA5);
    rx_state = 2'b01;
    rx_data  = 7'h52;
    rx_valid = 1'b1;
    @(negedge clk);
    check("lat_edge_cycle_valid", byte_valid, 0);
    @(negedge clk);
    check("lat_next_cycle_valid", byte_valid, 1);
    check("lat_next_cycle_data", byte_data, 8'hA5);
    step();
    rx_valid = 1'b0;
    rx_state = 2'b00;
    check("clean_err_count", err_count, 0);
    byte_ready = 1'b1;
    step(3);
    check("clean_drained", 32'(exp_q.size()), 0);

    // Table-driven vectors (byte_ready held high)
    for (int r = 0; r < 13; r++) begin
      send_byte(vecs[r].lo_cw, vecs[r].hi_cw, vecs[r].exp_byte);
      exp_pulses  += vecs[r].exp_errs;
      exp_err_cnt += vecs[r].exp_errs;
    end
    step(3);
    check("vec_drained", 32'(exp_q.size()), 0);
    check("vec_err_count", err_count, 32'(exp_err_cnt));
    check("vec_err_pulses", 32'(err_pulses), 32'(exp_pulses));

    // Timeout: dangling low nibble discarded after exactly 96 idle ticks
    send_cw(7'h2D);
    ticks = 0;
    seen  = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (timeout) seen = 1'b1;
      else if (rx_ena) ticks++;
    end
    check("tmo_seen", seen, 1);
    check("tmo_ticks", 32'(ticks), 32'(TIMEOUT_TICKS));
    @(negedge clk);
    check("tmo_pulse_one_cycle", timeout, 0);
    check("tmo_no_byte", byte_valid, 0);
    step();
    send_byte(7'h2D, 7'h52, 8'hA5);
    step(2);
    check("tmo_after_drained", 32'(exp_q.size()), 0);

    // Overflow: four fit, the fifth is dropped
    byte_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_byte(enc(4'(k)), enc(4'(k + 1)), {4'(k + 1), 4'(k)}, k < FIFO_DEPTH);
      @(negedge clk);
      if (k == FIFO_DEPTH - 1) check("ovf_not_yet", overflow, 0);
      step();
    end
    @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_head", byte_data, 8'h10);
    step();
    // Push into a full FIFO with a pop in the same cycle: nothing lost
    send_cw(enc(4'h9));
    exp_q.push_back(8'hA9);
    send_cw(enc(4'hA), 1'b1);
    check("ovf_sticky", overflow, 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    exp_err_cnt = 0;
    @(negedge clk);
    check("clr_overflow", overflow, 0);
    check("clr_err_count", err_count, 0);
    step();
    byte_ready = 1'b1;
    step(6);
    check("ovf_drained", 32'(exp_q.size()), 0);
    check("ovf_empty", byte_valid, 0);

    // Enable drop after a low nibble: pairing restarts, FIFO kept
    byte_ready = 1'b0;
    send_byte(enc(4'h3), enc(4'h4), 8'h43);
    send_cw(enc(4'h5));
    enable = 1'b0;
    step(2);
    @(negedge clk);
    check("en_fifo_kept_valid", byte_valid, 1);
    check("en_fifo_kept_data", byte_data, 8'h43);
    check("en_no_tick", rx_ena, 0);
    step();
    enable = 1'b1;
    send_byte(enc(4'h6), enc(4'h7), 8'h76);
    byte_ready = 1'b1;
    step(4);
    check("en_drained", 32'(exp_q.size()), 0);

    // Async reset after a low nibble: everything cleared, pairing restarts
    byte_ready = 1'b0;
    send_byte(enc(4'h1), enc(4'h2), 8'h21);
    send_cw(enc(4'h8));
    rst_n = 1'b0;
    #2;
    check("arst_immediate_valid", byte_valid, 0);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("arst_byte_valid", byte_valid, 0);
    check("arst_err_count", err_count, 0);
    check("arst_overflow", overflow, 0);
    step();
    send_byte(enc(4'hC), enc(4'hD), 8'hDC);
    byte_ready = 1'b1;
    step(4);
    check("arst_drained", 32'(exp_q.size()), 0);
    check("final_err_pulses", 32'(err_pulses), 32'(exp_pulses));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
